// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, stall encoding,
// load-width encodings and EX->MEM bus field positions.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 80;
    localparam int MEM_TO_WB_WD = 70;
    localparam int STALL_WD     = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    typedef enum logic [3:0] {
        RDEN_LW  = 4'b0000,
        RDEN_LB  = 4'b0001,
        RDEN_LBU = 4'b0010,
        RDEN_LH  = 4'b0011,
        RDEN_LHU = 4'b0100
    } readen_e;

    localparam int EM_READEN_LSB  = 76;
    localparam int EM_PC_LSB      = 44;
    localparam int EM_RAM_EN      = 43;
    localparam int EM_RAM_WEN_LSB = 39;
    localparam int EM_SEL_RF_RES  = 38;
    localparam int EM_RF_WE       = 37;
    localparam int EM_RF_WADDR_LSB = 32;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load formatter: picks the byte/halfword addressed by the low
// address bits out of a 32-bit read word and sign- or zero-extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rd,
    input  logic [1:0]  i_a,
    input  logic [3:0]  i_readen,
    output logic [31:0] o_aligned
);

    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_sh   = {i_a, 3'b000};
    assign w_byte = i_rd[w_sh +: 8];
    // Halfword select uses only a[1]; a misaligned a[0] is deliberately ignored.
    assign w_half = i_a[1] ? i_rd[31:16] : i_rd[15:0];

    always_comb begin
        o_aligned = i_rd;
        case (i_readen)
            RDEN_LB:  o_aligned = {{24{w_byte[7]}}, w_byte};
            RDEN_LBU: o_aligned = {24'h000000, w_byte};
            RDEN_LH:  o_aligned = {{16{w_half[15]}}, w_half};
            RDEN_LHU: o_aligned = {16'h0000, w_half};
            default:  o_aligned = i_rd;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, formats load data from the
// data SRAM and drives the MEM->WB and MEM->ID forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id,
    output logic                    mem_is_load
);

    logic [EX_TO_MEM_WD-1:0] r_bus;
    logic                    r_fresh;
    logic [31:0]             r_rdata_hold;

    logic [3:0]  w_readen;
    logic [31:0] w_pc;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_sel_rf_res;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_ex_result;
    logic [31:0] w_rd;
    logic [31:0] w_aligned;
    logic [31:0] w_rf_wdata;
    logic        w_is_load;
    logic        w_unused;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus        <= '0;
            r_fresh      <= 1'b0;
            r_rdata_hold <= 32'h0;
        end else begin
            if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NOSTOP) begin
                r_bus   <= '0;
                r_fresh <= 1'b0;
            end else if (stall[STALL_MEM] == NOSTOP) begin
                r_bus   <= ex_to_mem_bus;
                r_fresh <= 1'b1;
            end else begin
                r_fresh <= 1'b0;
            end
            // SRAM data is only valid in the first MEM cycle; keep it for stalls.
            if (r_fresh) begin
                r_rdata_hold <= data_sram_rdata;
            end
        end
    end

    assign w_readen     = r_bus[EM_READEN_LSB +: 4];
    assign w_pc         = r_bus[EM_PC_LSB +: 32];
    assign w_ram_en     = r_bus[EM_RAM_EN];
    assign w_ram_wen    = r_bus[EM_RAM_WEN_LSB +: 4];
    assign w_sel_rf_res = r_bus[EM_SEL_RF_RES];
    assign w_rf_we      = r_bus[EM_RF_WE];
    assign w_rf_waddr   = r_bus[EM_RF_WADDR_LSB +: 5];
    assign w_ex_result  = r_bus[31:0];

    assign w_rd      = r_fresh ? data_sram_rdata : r_rdata_hold;
    assign w_is_load = w_ram_en & (w_ram_wen == 4'b0000) & w_sel_rf_res;

    mem_load_align u_align (
        .i_rd      (w_rd),
        .i_a       (w_ex_result[1:0]),
        .i_readen  (w_readen),
        .o_aligned (w_aligned)
    );

    assign w_rf_wdata    = w_is_load ? w_aligned : w_ex_result;
    assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_to_id     = {w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_is_load   = w_is_load;

    assign w_unused = &{1'b0, stall[5], stall[2:0]};

endmodule
